// File: rtl/npu_loader_pkg.sv
// Shared types and sizing for the sparse chunk loader.
// Geometry is fixed here so stage modules agree on widths.
package npu_loader_pkg;

  localparam int MEM_SIZE        = 128;
  localparam int BUS_SIZE        = 32;
  localparam int PREFIX_SUM_SIZE = 8;
  localparam int SRC_ADDR_W      = 12;

  function automatic int beats_of(int mem, int bus);
    return mem / bus;
  endfunction

  function automatic int segs_of(int mem, int ps);
    return mem / ps;
  endfunction

  function automatic int spb_of(int bus, int ps);
    return bus / ps;
  endfunction

  localparam int BEATS = beats_of(MEM_SIZE, BUS_SIZE);
  localparam int SEGS  = segs_of(MEM_SIZE, PREFIX_SUM_SIZE);
  localparam int SPB   = spb_of(BUS_SIZE, PREFIX_SUM_SIZE);

  localparam int BEAT_W = $clog2(BEATS);
  localparam int SEG_W  = $clog2(SEGS);
  localparam int SUB_W  = (SPB > 1) ? $clog2(SPB) : 1;

  typedef logic [BEAT_W-1:0] beat_idx_t;
  typedef logic [SEG_W-1:0]  seg_idx_t;
  typedef logic [SUB_W-1:0]  sub_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/seg_last_finder.sv
// Finds the highest non-empty segment within one write beat.
// Purely combinational; any_o is low when the beat is all zero.
import npu_loader_pkg::*;

module seg_last_finder (
  input  logic [BUS_SIZE-1:0] sparsemap_i,
  output logic                any_o,
  output sub_idx_t            seg_o
);

  // Ascending scan: the last nonzero segment seen wins.
  always_comb begin
    any_o = 1'b0;
    seg_o = '0;
    for (int s = 0; s < SPB; s++) begin
      if (|sparsemap_i[s*PREFIX_SUM_SIZE +: PREFIX_SUM_SIZE]) begin
        any_o = 1'b1;
        seg_o = sub_idx_t'(s);
      end
    end
  end

endmodule

// File: rtl/sparse_chunk_loader.sv
// Streams one chunk per start from source SRAM into a double-banked
// chunk memory, tracking bank occupancy and the last non-empty segment.
import npu_loader_pkg::*;

module sparse_chunk_loader (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  input  logic [SRC_ADDR_W-1:0] chunk_base_i,
  output logic                  start_ready_o,
  input  logic                  bank_release_i,
  input  logic                  bank_release_sel_i,
  output logic [1:0]            bank_full_o,
  output logic                  src_rd_en_o,
  output logic [SRC_ADDR_W-1:0] src_rd_addr_o,
  input  logic [BUS_SIZE-1:0]   src_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0] src_data_i,
  output logic                  wr_valid_o,
  output logic [BEAT_W-1:0]     wr_count_o,
  output logic                  wr_sel_o,
  output logic [BUS_SIZE-1:0]   wr_sparsemap_o,
  output logic [BUS_SIZE*8-1:0] wr_nonzero_data_o,
  output logic                  chunk_done_o,
  output logic [SEG_W-1:0]      chunk_last_seg_o,
  output logic                  chunk_empty_o
);

  state_t                  state_q, state_d;
  beat_idx_t               cnt_q;
  logic [SRC_ADDR_W-1:0]   base_q;
  logic                    bank_q;
  logic                    next_sel_q;
  logic [1:0]              full_q, full_d;
  logic                    wr_valid_q;
  beat_idx_t               wr_count_q;
  logic                    trk_any_q, trk_any_d;
  seg_idx_t                trk_seg_q, trk_seg_d;
  logic                    done_q;
  seg_idx_t                last_seg_q;
  logic                    empty_q;

  logic                    start_acc;
  logic                    drain_exit;
  logic                    rd_en;
  logic                    beat_any;
  sub_idx_t                beat_sub;
  seg_idx_t                cand;
  logic                    hit;

  assign start_ready_o = (state_q == IDLE) && !full_q[next_sel_q];
  assign start_acc     = start_i && start_ready_o;
  assign drain_exit    = (state_q == DRAIN);
  assign rd_en         = (state_q == READ);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_acc) state_d = READ;
      READ:    if (cnt_q == beat_idx_t'(BEATS-1)) state_d = DRAIN;
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  seg_last_finder u_find (
    .sparsemap_i (src_sparsemap_i),
    .any_o       (beat_any),
    .seg_o       (beat_sub)
  );

  assign cand = SEG_W'(wr_count_q) * SEG_W'(SPB) + SEG_W'(beat_sub);
  assign hit  = wr_valid_q && beat_any;

  // Beats arrive in order, so the newest hit is always the maximum.
  assign trk_any_d = trk_any_q | hit;
  assign trk_seg_d = hit ? cand : trk_seg_q;

  // The bank under load cannot be released; set and clear may coincide.
  always_comb begin
    full_d = full_q;
    if (bank_release_i &&
        !((state_q != IDLE) && (bank_release_sel_i == bank_q)))
      full_d[bank_release_sel_i] = 1'b0;
    if (drain_exit)
      full_d[bank_q] = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      base_q     <= '0;
      bank_q     <= 1'b0;
      next_sel_q <= 1'b0;
      full_q     <= 2'b00;
      wr_valid_q <= 1'b0;
      wr_count_q <= '0;
      trk_any_q  <= 1'b0;
      trk_seg_q  <= '0;
      done_q     <= 1'b0;
      last_seg_q <= '0;
      empty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= rd_en ? cnt_q + 1'b1 : '0;
      wr_valid_q <= rd_en;
      wr_count_q <= cnt_q;
      done_q     <= drain_exit;
      full_q     <= full_d;
      if (start_acc) begin
        base_q    <= chunk_base_i;
        bank_q    <= next_sel_q;
        trk_any_q <= 1'b0;
        trk_seg_q <= '0;
      end else begin
        trk_any_q <= trk_any_d;
        trk_seg_q <= trk_seg_d;
      end
      if (drain_exit) begin
        last_seg_q <= trk_any_d ? trk_seg_d : '0;
        empty_q    <= !trk_any_d;
        next_sel_q <= ~next_sel_q;
      end
    end
  end

  assign src_rd_en_o       = rd_en;
  assign src_rd_addr_o     = rd_en ? base_q + SRC_ADDR_W'(cnt_q) : '0;
  assign bank_full_o       = full_q;
  assign wr_valid_o        = wr_valid_q;
  assign wr_count_o        = wr_count_q;
  assign wr_sel_o          = bank_q;
  assign wr_sparsemap_o    = src_sparsemap_i;
  assign wr_nonzero_data_o = src_data_i;
  assign chunk_done_o      = done_q;
  assign chunk_last_seg_o  = last_seg_q;
  assign chunk_empty_o     = empty_q;

endmodule
